// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types for the instruction fetch path: FSM states, fault causes, and the NOP encoding.
package JZJCoreFTypes;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        HOLD     = 2'd2,
        FAULT    = 2'd3
    } FetchState_t;

    typedef enum logic [1:0] {
        NONE       = 2'd0,
        MISALIGNED = 2'd1,
        TIMEOUT    = 2'd2
    } FetchFault_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTRUCTION = 32'h00000013;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-port bus between the fetch unit (master) and the memory controller (slave).
interface instruction_fetch_unit_if;

    logic        memReadEnable;
    logic [31:0] memAddress;
    logic        memReadValid;
    logic [31:0] memReadData;

    modport master (
        output memReadEnable,
        output memAddress,
        input  memReadValid,
        input  memReadData
    );

    modport slave (
        input  memReadEnable,
        input  memAddress,
        output memReadValid,
        output memReadData
    );

endinterface

// File: rtl/fetch_watchdog_counter.sv
// Saturating cycle counter that flags when a memory wait has run WATCHDOG_CYCLES cycles.
module fetch_watchdog_counter #(
    parameter int WATCHDOG_CYCLES = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (WATCHDOG_CYCLES == 0) ? 1 : $clog2(WATCHDOG_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'((WATCHDOG_CYCLES == 0) ? 0 : WATCHDOG_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable && (count != '1))
            count <= count + 1'b1;
    end

    assign expired = (WATCHDOG_CYCLES != 0) && (count == LAST);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch controller: issues one memory read per request, holds the word for decode,
// and latches misalignment/timeout faults. Responses overtaken by a flush are dropped.
module instruction_fetch_unit
    import JZJCoreFTypes::*;
#(
    parameter int          WATCHDOG_CYCLES = 255,
    parameter logic [31:0] NOP_WORD        = NOP_INSTRUCTION
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     fetchRequest,
    input  logic [31:0]              instructionAddressToAccess,
    input  logic                     flush,
    instruction_fetch_unit_if.master memBus,
    output logic [31:0]              instruction,
    output logic                     instructionValid,
    input  logic                     decodeReady,
    output logic [31:0]              pcOfFetchedInstruction,
    output logic                     fetchFault,
    output FetchFault_t              faultCause
);

    FetchState_t state, stateNext;
    logic        memReadEnable, memReadEnableNext;
    logic [31:0] memAddress, memAddressNext;
    logic [31:0] instructionNext, pcNext;
    logic        instructionValidNext, fetchFaultNext, flushPending, flushPendingNext;
    FetchFault_t faultCauseNext;
    logic        issue, wdClear, wdEnable, wdExpired;

    fetch_watchdog_counter #(.WATCHDOG_CYCLES(WATCHDOG_CYCLES)) watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear   (wdClear),
        .enable  (wdEnable),
        .expired (wdExpired)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state                  <= IDLE;
            memReadEnable          <= 1'b0;
            memAddress             <= '0;
            instruction            <= NOP_WORD;
            instructionValid       <= 1'b0;
            pcOfFetchedInstruction <= '0;
            fetchFault             <= 1'b0;
            faultCause             <= NONE;
            flushPending           <= 1'b0;
        end else begin
            state                  <= stateNext;
            memReadEnable          <= memReadEnableNext;
            memAddress             <= memAddressNext;
            instruction            <= instructionNext;
            instructionValid       <= instructionValidNext;
            pcOfFetchedInstruction <= pcNext;
            fetchFault             <= fetchFaultNext;
            faultCause             <= faultCauseNext;
            flushPending           <= flushPendingNext;
        end
    end

    always_comb begin
        stateNext            = state;
        memReadEnableNext    = memReadEnable;
        memAddressNext       = memAddress;
        instructionNext      = instruction;
        instructionValidNext = instructionValid;
        pcNext               = pcOfFetchedInstruction;
        fetchFaultNext       = fetchFault;
        faultCauseNext       = faultCause;
        flushPendingNext     = flushPending;
        issue                = 1'b0;
        wdClear              = 1'b0;
        wdEnable             = 1'b0;

        unique case (state)
            IDLE: issue = fetchRequest && !flush;
            WAIT_MEM: begin
                wdEnable = 1'b1;
                if (memBus.memReadValid) begin
                    memReadEnableNext = 1'b0;
                    flushPendingNext  = 1'b0;
                    if (flushPending || flush) begin
                        stateNext = IDLE;
                    end else begin
                        instructionNext      = memBus.memReadData;
                        instructionValidNext = 1'b1;
                        stateNext            = HOLD;
                    end
                end else if (wdExpired) begin
                    // Nothing is outstanding after a timeout, so any pending flush is moot.
                    memReadEnableNext = 1'b0;
                    flushPendingNext  = 1'b0;
                    fetchFaultNext    = 1'b1;
                    faultCauseNext    = TIMEOUT;
                    stateNext         = FAULT;
                end else if (flush) begin
                    flushPendingNext = 1'b1;
                end
            end
            HOLD: begin
                if (flush || decodeReady) begin
                    instructionValidNext = 1'b0;
                    instructionNext      = NOP_WORD;
                    stateNext            = IDLE;
                    issue                = !flush && fetchRequest;
                end
            end
            FAULT: begin
                if (flush) begin
                    fetchFaultNext = 1'b0;
                    faultCauseNext = NONE;
                    stateNext      = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase

        if (issue) begin
            memAddressNext = instructionAddressToAccess;
            pcNext         = instructionAddressToAccess;
            if (instructionAddressToAccess[1:0] != 2'b00) begin
                fetchFaultNext = 1'b1;
                faultCauseNext = MISALIGNED;
                stateNext      = FAULT;
            end else begin
                memReadEnableNext = 1'b1;
                wdClear           = 1'b1;
                stateNext         = WAIT_MEM;
            end
        end
    end

    assign memBus.memReadEnable = memReadEnable;
    assign memBus.memAddress    = memAddress;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a 4-cycle watchdog.
module tb_instruction_fetch_unit;
    import JZJCoreFTypes::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        fetchRequest;
    logic [31:0] instructionAddressToAccess;
    logic        flush;
    logic [31:0] instruction;
    logic        instructionValid;
    logic        decodeReady;
    logic [31:0] pcOfFetchedInstruction;
    logic        fetchFault;
    FetchFault_t faultCause;

    int checks = 0;
    int errors = 0;

    instruction_fetch_unit_if memBus ();

    instruction_fetch_unit #(.WATCHDOG_CYCLES(4)) dut (
        .clock                      (clock),
        .reset                      (reset),
        .fetchRequest               (fetchRequest),
        .instructionAddressToAccess (instructionAddressToAccess),
        .flush                      (flush),
        .memBus                     (memBus.master),
        .instruction                (instruction),
        .instructionValid           (instructionValid),
        .decodeReady                (decodeReady),
        .pcOfFetchedInstruction     (pcOfFetchedInstruction),
        .fetchFault                 (fetchFault),
        .faultCause                 (faultCause)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic chkHandshake(input string tag, input logic ren, input logic [31:0] addr);
        chk({tag, "_ren"},  32'(memBus.memReadEnable), 32'(ren));
        chk({tag, "_addr"}, memBus.memAddress, addr);
    endtask

    task automatic chkWord(input string tag, input logic vld, input logic [31:0] word);
        chk({tag, "_valid"}, 32'(instructionValid), 32'(vld));
        chk({tag, "_instr"}, instruction, word);
    endtask

    task automatic chkFault(input string tag, input logic flt, input logic [1:0] cause);
        chk({tag, "_fault"}, 32'(fetchFault), 32'(flt));
        chk({tag, "_cause"}, 32'(faultCause), 32'(cause));
    endtask

    initial begin
        reset = 1'b1;
        fetchRequest = 1'b0;
        instructionAddressToAccess = '0;
        flush = 1'b0;
        decodeReady = 1'b0;
        memBus.memReadValid = 1'b0;
        memBus.memReadData = '0;
        tick();
        tick();

        chkHandshake("rst", 1'b0, 32'h0);
        chkWord("rst", 1'b0, 32'h00000013);
        chk("rst_pc", pcOfFetchedInstruction, 32'h0);
        chkFault("rst", 1'b0, 2'd0);
        reset = 1'b0;

        // basic fetch, memory latency 1
        fetchRequest = 1'b1; instructionAddressToAccess = 32'h100;
        tick();
        chkHandshake("basic_req", 1'b1, 32'h100);
        chk("basic_req_valid", 32'(instructionValid), 32'd0);
        fetchRequest = 1'b0;
        memBus.memReadValid = 1'b1; memBus.memReadData = 32'h00500093;
        tick();
        memBus.memReadValid = 1'b0;
        chkHandshake("basic_rsp", 1'b0, 32'h100);
        chkWord("basic_rsp", 1'b1, 32'h00500093);
        chk("basic_pc", pcOfFetchedInstruction, 32'h100);
        tick();
        chkWord("basic_hold", 1'b1, 32'h00500093);
        decodeReady = 1'b1;
        tick();
        decodeReady = 1'b0;
        chkWord("basic_consume", 1'b0, 32'h00000013);

        // misaligned fetch
        fetchRequest = 1'b1; instructionAddressToAccess = 32'h102;
        tick();
        fetchRequest = 1'b0;
        chk("mis_ren", 32'(memBus.memReadEnable), 32'd0);
        chkFault("mis", 1'b1, 2'd1);
        chk("mis_pc", pcOfFetchedInstruction, 32'h102);
        fetchRequest = 1'b1; instructionAddressToAccess = 32'h104;
        tick();
        fetchRequest = 1'b0;
        chk("mis_ignore_req_ren", 32'(memBus.memReadEnable), 32'd0);
        chkFault("mis_sticky", 1'b1, 2'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chkFault("mis_flush", 1'b0, 2'd0);
        fetchRequest = 1'b1; instructionAddressToAccess = 32'h104;
        tick();
        fetchRequest = 1'b0;
        chkHandshake("mis_retry", 1'b1, 32'h104);
        tick();
        memBus.memReadValid = 1'b1; memBus.memReadData = 32'h00A00113;
        tick();
        memBus.memReadValid = 1'b0;
        chkWord("mis_retry", 1'b1, 32'h00A00113);
        chk("mis_retry_pc", pcOfFetchedInstruction, 32'h104);

        // back-to-back: consume and request in the same HOLD cycle
        decodeReady = 1'b1; fetchRequest = 1'b1; instructionAddressToAccess = 32'h108;
        tick();
        decodeReady = 1'b0; fetchRequest = 1'b0;
        chkWord("b2b", 1'b0, 32'h00000013);
        chkHandshake("b2b", 1'b1, 32'h108);
        memBus.memReadValid = 1'b1; memBus.memReadData = 32'h11111111;
        tick();
        memBus.memReadValid = 1'b0;
        chkWord("b2b_rsp", 1'b1, 32'h11111111);
        chk("b2b_pc", pcOfFetchedInstruction, 32'h108);
        decodeReady = 1'b1;
        tick();
        decodeReady = 1'b0;

        // flush while the read is in flight, response at latency 3
        fetchRequest = 1'b1; instructionAddressToAccess = 32'h200;
        tick();
        fetchRequest = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chkHandshake("fl_pending", 1'b1, 32'h200);
        tick();
        memBus.memReadValid = 1'b1; memBus.memReadData = 32'hDEADBEEF;
        tick();
        memBus.memReadValid = 1'b0;
        chkWord("fl_drop", 1'b0, 32'h00000013);
        chk("fl_drop_ren", 32'(memBus.memReadEnable), 32'd0);
        tick();
        chk("fl_idle_valid", 32'(instructionValid), 32'd0);
        fetchRequest = 1'b1; instructionAddressToAccess = 32'h300;
        tick();
        fetchRequest = 1'b0;
        chkHandshake("fl_next", 1'b1, 32'h300);
        memBus.memReadValid = 1'b1; memBus.memReadData = 32'h00300193;
        tick();
        memBus.memReadValid = 1'b0;
        chkWord("fl_next", 1'b1, 32'h00300193);
        decodeReady = 1'b1;
        tick();
        decodeReady = 1'b0;

        // watchdog timeout after 4 cycles
        fetchRequest = 1'b1; instructionAddressToAccess = 32'h400;
        tick();
        fetchRequest = 1'b0;
        chk("to_rise", 32'(memBus.memReadEnable), 32'd1);
        tick();
        tick();
        tick();
        chk("to_before_ren", 32'(memBus.memReadEnable), 32'd1);
        chkFault("to_before", 1'b0, 2'd0);
        tick();
        chk("to_ren", 32'(memBus.memReadEnable), 32'd0);
        chkFault("to", 1'b1, 2'd2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chkFault("to_flush", 1'b0, 2'd0);

        // reset during WAIT_MEM, then a late response
        fetchRequest = 1'b1; instructionAddressToAccess = 32'h500;
        tick();
        fetchRequest = 1'b0;
        chk("rm_ren", 32'(memBus.memReadEnable), 32'd1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        memBus.memReadValid = 1'b1; memBus.memReadData = 32'hCAFEBABE;
        tick();
        memBus.memReadValid = 1'b0;
        chkHandshake("rm", 1'b0, 32'h0);
        chkWord("rm", 1'b0, 32'h00000013);
        chk("rm_pc", pcOfFetchedInstruction, 32'h0);
        chkFault("rm", 1'b0, 2'd0);
        tick();
        chk("rm_late_valid", 32'(instructionValid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
